// File: rtl/bgw_renderer_if.sv
// rtl/bgw_renderer_if.sv - FSX timing, VRAM8/VRAM32 and colour signals for the BG/window renderer
interface bgw_renderer_if;
  logic [9:0]  h_count;
  logic [8:0]  v_count;
  logic        vga_hs;
  logic        vga_vs;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic        o_frame;
  logic [8:0]  o_h;
  logic [7:0]  o_v;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [1:0]  vga_b;
  logic [13:0] vram32_addr;
  logic [31:0] vram32_q;
  logic [13:0] vram8_addr;
  logic [7:0]  vram8_q;

  modport master (
    output h_count, v_count, vga_hs, vga_vs, o_hs, o_vs, o_de, o_frame, o_h, o_v,
    output vram32_q, vram8_q,
    input  vga_r, vga_g, vga_b, vram32_addr, vram8_addr
  );

  modport slave (
    input  h_count, v_count, vga_hs, vga_vs, o_hs, o_vs, o_de, o_frame, o_h, o_v,
    input  vram32_q, vram8_q,
    output vga_r, vga_g, vga_b, vram32_addr, vram8_addr
  );
endinterface

// File: rtl/bgw_renderer.sv
// rtl/bgw_renderer.sv - background/window tile renderer: 8-cycle VRAM fetch slots feeding 2bpp pixel registers
module bgw_renderer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int H_FP   = 24,
  parameter int H_SYNC = 32,
  parameter int H_BP   = 46,
  parameter int V_FP   = 3,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 14,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0
) (
  input  logic          vga_clk,
  input  logic          reset,
  bgw_renderer_if.slave bus
);
  localparam int HA_STA  = H_FP - 1 + H_SYNC + H_BP;
  localparam int VA_STA  = V_FP - 1 + V_SYNC + V_BP;
  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int SLOTS   = H_RES / 8;

  localparam logic [13:0] BG_TILE  = 14'h0000;
  localparam logic [13:0] BG_COL   = 14'h0800;
  localparam logic [13:0] WIN_TILE = 14'h1000;
  localparam logic [13:0] WIN_COL  = 14'h14B0;
  localparam logic [13:0] SCROLL   = 14'h1960;
  localparam logic [13:0] PAL_BASE = 14'd1024;

  logic [13:0] r_vram8_addr;
  logic [13:0] r_vram32_addr;
  logic [5:0]  r_scroll;
  logic        r_armed;
  logic [15:0] r_bg_pat;
  logic [31:0] r_bg_palw;
  logic [15:0] r_win_pat;
  logic [31:0] r_win_palw;
  logic [15:0] r_bg_pix;
  logic [31:0] r_bg_pal;
  logic [15:0] r_win_pix;
  logic [31:0] r_win_pal;

  logic        w_line_act;
  logic [8:0]  w_y9;
  logic [7:0]  w_y;
  logic [4:0]  w_row;
  logic [2:0]  w_tl;
  logic [9:0]  w_pos;
  logic [9:0]  w_pos_n;
  logic        w_slot;
  logic        w_slot_n;
  logic [2:0]  w_c;
  logic [2:0]  w_c_n;
  logic [5:0]  w_k_n;
  logic [5:0]  w_bg_col;
  logic [13:0] w_bg_ent;
  logic [13:0] w_win_ent;
  logic [13:0] w_pat_addr;
  logic [13:0] w_pal_addr;
  logic [15:0] w_pat_half;

  assign w_line_act = (bus.v_count >= 9'(VA_STA + 1)) && (bus.v_count <= 9'(VA_STA + V_RES));
  assign w_y9       = bus.v_count - 9'(VA_STA + 1);
  assign w_y        = w_y9[7:0];
  assign w_row      = w_y[7:3];
  assign w_tl       = w_y[2:0];

  // w_pos is the slot position of this cycle; w_pos_n that of the next cycle,
  // since addresses are registered one cycle ahead of the cycle they belong to.
  assign w_pos    = bus.h_count - 10'(HA_STA - 7);
  assign w_pos_n  = bus.h_count - 10'(HA_STA - 8);
  assign w_slot   = w_line_act && (w_pos < 10'(8 * SLOTS));
  assign w_slot_n = w_line_act && (w_pos_n < 10'(8 * SLOTS));
  assign w_c      = w_pos[2:0];
  assign w_c_n    = w_pos_n[2:0];
  assign w_k_n    = w_pos_n[8:3];

  assign w_bg_col   = w_k_n + r_scroll;
  assign w_bg_ent   = {3'b000, w_row, w_bg_col};
  assign w_win_ent  = {4'b0000, w_row, 5'b00000} + {6'b000000, w_row, 3'b000} + {8'h00, w_k_n};
  assign w_pat_addr = {4'b0000, bus.vram8_q, w_tl[2:1]};
  assign w_pal_addr = PAL_BASE + {9'b0_0000_0000, bus.vram8_q[4:0]};
  assign w_pat_half = w_tl[0] ? bus.vram32_q[15:0] : bus.vram32_q[31:16];

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_vram8_addr  <= 14'd0;
      r_vram32_addr <= 14'd0;
      r_scroll      <= 6'd0;
      r_armed       <= 1'b0;
      r_bg_pat      <= 16'd0;
      r_bg_palw     <= 32'd0;
      r_win_pat     <= 16'd0;
      r_win_palw    <= 32'd0;
      r_bg_pix      <= 16'd0;
      r_bg_pal      <= 32'd0;
      r_win_pix     <= 16'd0;
      r_win_pal     <= 32'd0;
    end else begin
      if (bus.h_count == 10'(H_TOTAL - 1)) begin
        r_vram8_addr <= SCROLL;
      end
      if (bus.h_count == 10'd1) begin
        r_scroll <= bus.vram8_q[5:0];
      end

      if (w_slot_n) begin
        case (w_c_n)
          3'd0: r_vram8_addr <= BG_TILE + w_bg_ent;
          3'd1: r_vram8_addr <= BG_COL + w_bg_ent;
          3'd2: begin
            r_vram8_addr  <= WIN_TILE + w_win_ent;
            r_vram32_addr <= w_pat_addr;
          end
          3'd3: begin
            r_vram8_addr  <= WIN_COL + w_win_ent;
            r_vram32_addr <= w_pal_addr;
          end
          3'd4: r_vram32_addr <= w_pat_addr;
          3'd5: r_vram32_addr <= w_pal_addr;
          default: ;
        endcase
      end

      // After a reset the registers stay cleared until a line starts from slot 0.
      if (w_slot) begin
        case (w_c)
          3'd0: begin
            if (w_pos[9:3] == 7'd0) begin
              r_armed <= 1'b1;
            end
          end
          3'd3: r_bg_pat   <= w_pat_half;
          3'd4: r_bg_palw  <= bus.vram32_q;
          3'd5: r_win_pat  <= w_pat_half;
          3'd6: r_win_palw <= bus.vram32_q;
          3'd7: begin
            if (r_armed) begin
              r_bg_pix  <= r_bg_pat;
              r_bg_pal  <= r_bg_palw;
              r_win_pix <= r_win_pat;
              r_win_pal <= r_win_palw;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [3:0] w_pix_hi;
  logic [1:0] w_bg_idx;
  logic [1:0] w_win_idx;
  logic [4:0] w_bg_sel;
  logic [4:0] w_win_sel;
  logic [7:0] w_colour;

  always_comb begin
    w_pix_hi  = 4'd15 - {bus.o_h[2:0], 1'b0};
    w_bg_idx  = r_bg_pix[w_pix_hi -: 2];
    w_win_idx = r_win_pix[w_pix_hi -: 2];
    w_bg_sel  = 5'd31 - {w_bg_idx, 3'b000};
    w_win_sel = 5'd31 - {w_win_idx, 3'b000};
    w_colour  = 8'h00;
    if (bus.o_de) begin
      w_colour = (w_win_idx != 2'd0) ? r_win_pal[w_win_sel -: 8] : r_bg_pal[w_bg_sel -: 8];
    end
  end

  assign bus.vga_r       = w_colour[7:5];
  assign bus.vga_g       = w_colour[4:2];
  assign bus.vga_b       = w_colour[1:0];
  assign bus.vram8_addr  = r_vram8_addr;
  assign bus.vram32_addr = r_vram32_addr;

  logic w_unused;
  assign w_unused = ^{bus.vga_hs, bus.vga_vs, bus.o_hs, bus.o_vs, bus.o_frame,
                      bus.o_h[8:3], bus.o_v, w_y9[8], 1'(H_POL), 1'(V_POL)};
endmodule

// File: tb/tb_bgw_renderer.sv
// tb/tb_bgw_renderer.sv - self-checking bench for bgw_renderer against a tile/palette lookup model
module tb_bgw_renderer;
  localparam int HA_STA  = 101;
  localparam int VA_STA  = 21;
  localparam int H_RES   = 320;
  localparam int H_TOTAL = 422;
  localparam int SCR_A   = 6496;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [7:0]  mem8  [0:16383];
  logic [31:0] mem32 [0:16383];
  logic [7:0]  line_pix [0:319];

  bgw_renderer_if bus();
  bgw_renderer dut (.vga_clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.vram8_q  <= mem8[bus.vram8_addr];
    bus.vram32_q <= mem32[bus.vram32_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_pix(input int x, input int y, input int scr);
    int k, p, r, l, col, bt, bp, wt, wp, bi, wi;
    logic [31:0] bw, ww;
    logic [15:0] bh, wh;
    k = x / 8; p = x % 8; r = y / 8; l = y % 8;
    col = (k + scr) % 64;
    bt = int'(mem8[r * 64 + col]);
    bp = int'(mem8[2048 + r * 64 + col]) % 32;
    wt = int'(mem8[4096 + r * 40 + k]);
    wp = int'(mem8[5296 + r * 40 + k]) % 32;
    bw = mem32[bt * 4 + l / 2];
    ww = mem32[wt * 4 + l / 2];
    bh = (l % 2 == 0) ? bw[31:16] : bw[15:0];
    wh = (l % 2 == 0) ? ww[31:16] : ww[15:0];
    bi = int'(bh >> (14 - 2 * p)) & 3;
    wi = int'(wh >> (14 - 2 * p)) & 3;
    if (wi != 0) return 8'(mem32[1024 + wp] >> (24 - 8 * wi));
    return 8'(mem32[1024 + bp] >> (24 - 8 * bi));
  endfunction

  task automatic run_line(input int v, input int rst_at, input int scr_at, input logic [7:0] scr_val);
    int scr, y, h;
    bit act, de;
    logic [7:0] obs, exp;
    scr = 0;
    act = (v >= VA_STA + 1) && (v <= VA_STA + 240);
    y = v - (VA_STA + 1);
    for (h = 0; h < H_TOTAL; h++) begin
      @(posedge clk);
      #1;
      de = act && (h >= HA_STA + 1) && (h <= HA_STA + H_RES);
      bus.h_count = 10'(h);
      bus.v_count = 9'(v);
      bus.o_de    = de;
      bus.o_h     = de ? 9'(h - HA_STA - 1) : 9'd0;
      bus.o_v     = de ? 8'(y) : 8'd0;
      bus.vga_hs  = (h >= 24) && (h < 56);
      bus.o_hs    = bus.vga_hs;
      bus.vga_vs  = (v >= 3) && (v < 8);
      bus.o_vs    = bus.vga_vs;
      bus.o_frame = (v == 0) && (h == 0);
      reset = (rst_at >= 0) && (h == rst_at || h == rst_at + 1);
      if (h == scr_at) mem8[SCR_A] = scr_val;
      if (h == 0) scr = int'(mem8[SCR_A]) % 64;
      #2;
      if (h != rst_at) begin
        exp = de ? model_pix(h - HA_STA - 1, y, scr) : 8'h00;
        if (rst_at >= 0 && h > rst_at) exp = 8'h00;
        obs = {bus.vga_r, bus.vga_g, bus.vga_b};
        check($sformatf("pix v%0d h%0d", v, h), 32'(obs), 32'(exp));
        if (de) line_pix[h - HA_STA - 1] = obs;
      end
      if (act && h == HA_STA - 7)
        check($sformatf("addr8_c0 v%0d", v), 32'(bus.vram8_addr), 32'((y / 8) * 64 + scr));
      if (act && h == HA_STA - 5)
        check($sformatf("addr8_c2 v%0d", v), 32'(bus.vram8_addr), 32'(4096 + (y / 8) * 40));
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem8[i]  = 8'h00;
      mem32[i] = 32'h0;
    end
    bus.h_count = 10'd5; bus.v_count = 9'd0;
    bus.vga_hs = 1'b0; bus.vga_vs = 1'b0; bus.o_hs = 1'b0; bus.o_vs = 1'b0;
    bus.o_frame = 1'b0; bus.o_de = 1'b1; bus.o_h = 9'd0; bus.o_v = 8'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("rst_colour", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h0);
    check("rst_addr8", 32'(bus.vram8_addr), 32'h0);
    check("rst_addr32", 32'(bus.vram32_addr), 32'h0);
    reset = 1'b0;
    bus.o_de = 1'b0;

    // all-red screen, blanking black, first and last active lines
    mem32[1024] = 32'hE000_0000;
    run_line(21, -1, -1, 8'h00);
    run_line(22, -1, -1, 8'h00);
    check("red_px0", 32'(line_pix[0]), 32'hE0);
    check("red_px319", 32'(line_pix[319]), 32'hE0);
    run_line(261, -1, -1, 8'h00);
    check("last_line_px319", 32'(line_pix[319]), 32'hE0);

    // BG tile 1 with indices 0..3
    mem8[0] = 8'd1;
    mem32[4] = 32'h1B00_0000;
    mem32[1024] = 32'h00E0_1C03;
    run_line(22, -1, -1, 8'h00);
    check("bg_px0", 32'(line_pix[0]), 32'h00);
    check("bg_px1", 32'(line_pix[1]), 32'hE0);
    check("bg_px2", 32'(line_pix[2]), 32'h1C);
    check("bg_px3", 32'(line_pix[3]), 32'h03);

    // window over red BG, then transparent window
    mem8[0] = 8'd0;
    mem32[1024] = 32'hE000_0000;
    mem8[4096] = 8'd2;
    mem8[5296] = 8'd1;
    mem32[8] = 32'h5555_5555;
    mem32[1025] = 32'h00FF_0000;
    run_line(22, -1, -1, 8'h00);
    check("win_px0", 32'(line_pix[0]), 32'hFF);
    check("win_px7", 32'(line_pix[7]), 32'hFF);
    check("win_px8", 32'(line_pix[8]), 32'hE0);
    mem32[8] = 32'h0;
    run_line(22, -1, -1, 8'h00);
    check("win_clear_px0", 32'(line_pix[0]), 32'hE0);

    // scroll written mid-line takes effect on the following line
    mem8[4096] = 8'd0;
    mem8[1] = 8'd1;
    mem32[4] = 32'h1B00_1B00;
    mem32[1024] = 32'h00E0_1C03;
    run_line(22, -1, 200, 8'd1);
    check("scroll_old_px1", 32'(line_pix[1]), 32'h00);
    run_line(23, -1, -1, 8'h00);
    check("scroll_new_px1", 32'(line_pix[1]), 32'hE0);
    check("scroll_new_px3", 32'(line_pix[3]), 32'h03);

    // column wrap: screen tile 0 reads column 63, tile 1 reads column 0
    mem8[1] = 8'd0;
    mem8[63] = 8'd1;
    mem8[SCR_A] = 8'd63;
    run_line(22, -1, -1, 8'h00);
    check("wrap_px1", 32'(line_pix[1]), 32'hE0);
    check("wrap_px9", 32'(line_pix[9]), 32'h00);

    // random VRAM contents
    for (int it = 0; it < 10; it++) begin
      for (int a = 0; a <= SCR_A; a++) mem8[a] = 8'($urandom);
      for (int a = 0; a < 1056; a++) mem32[a] = $urandom;
      if (it == 0) run_line(261, -1, -1, 8'h00);
      else if (it == 5) begin
        run_line(30, 200, -1, 8'h00);
        run_line(31, -1, -1, 8'h00);
      end else run_line($urandom_range(22, 261), -1, -1, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
